stats_engine: RTL and testbench

- Parametrised successor to the pet-stat tracker. Holds NUM_STATS saturating stat counters of STAT_W bits each.
- A free-running tick divider raises one randomly selected stat per tick. Rising edges on per-stat action inputs lower the matching stat.
- Per-stat alert flags go to the display/FSM layer, which decides when the pet needs attention.
- One owner per stat register; increment and decrement are merged in a single update path.

---
 rtl/stats_pkg.sv | 29 ++
 rtl/stats_engine_if.sv | 19 +
 rtl/stat_channel.sv | 47 ++++
 rtl/stats_engine.sv | 73 +++++++
 tb/tb_stats_engine.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/stats_pkg.sv
// Shared constants, stat indices and the clamped add/sub helper for the stats engine.
package stats_pkg;

    localparam int unsigned STAT_W_DEF    = 4;
    localparam int unsigned TICK_DIV_DEF  = 10_000_000;
    localparam int unsigned ALERT_LVL_DEF = 12;

    localparam int unsigned STAT_HUNGER    = 0;
    localparam int unsigned STAT_HAPPINESS = 1;
    localparam int unsigned STAT_HEALTH    = 2;
    localparam int unsigned STAT_HYGIENE   = 3;
    localparam int unsigned STAT_ENERGY    = 4;
    localparam int unsigned STAT_SOCIAL    = 5;

    // Signed intermediate so an underflow clamps to zero instead of wrapping.
    function automatic int unsigned sat_add_sub(input int unsigned val,
                                                input int unsigned add,
                                                input int unsigned sub,
                                                input int unsigned maxv);
        int nxt;
        nxt = int'(val) + int'(add) - int'(sub);
        if (nxt < 0)
            return 0;
        if (nxt > int'(maxv))
            return maxv;
        return unsigned'(nxt);
    endfunction

endpackage

// File: rtl/stats_engine_if.sv
// Control/status bundle between the stats engine and the display/FSM layer.
interface stats_engine_if #(
    parameter int unsigned NUM_STATS = 6,
    parameter int unsigned STAT_W    = 4,
    parameter int unsigned SEL_W     = 3
);
    logic                          tick_en;
    logic [NUM_STATS-1:0]          inputs;
    logic [SEL_W-1:0]              random;
    logic [NUM_STATS*STAT_W-1:0]   stats;
    logic [NUM_STATS-1:0]          alert;
    logic                          any_alert;
    logic                          tick;

    modport master (output tick_en, inputs, random,
                    input  stats, alert, any_alert, tick);
    modport slave  (input  tick_en, inputs, random,
                    output stats, alert, any_alert, tick);
endinterface

// File: rtl/stat_channel.sv
// One stat register: action-line edge detect, clamped inc/dec update and alert flag.
module stat_channel
    import stats_pkg::*;
#(
    parameter int unsigned STAT_W    = STAT_W_DEF,
    parameter int unsigned INC_STEP  = 1,
    parameter int unsigned DEC_STEP  = 1,
    parameter int unsigned ALERT_LVL = ALERT_LVL_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              din,
    output logic [STAT_W-1:0] value,
    output logic              alert,
    output logic              alert_next
);
    localparam int unsigned MAXV = (1 << STAT_W) - 1;

    logic        prev;
    logic        dec;
    int unsigned add_amt;
    int unsigned sub_amt;
    int unsigned nxt;

    always_comb begin
        dec        = din && !prev;
        add_amt    = inc ? INC_STEP : 0;
        sub_amt    = dec ? DEC_STEP : 0;
        nxt        = sat_add_sub(32'(value), add_amt, sub_amt, MAXV);
        alert_next = (nxt >= ALERT_LVL);
    end

    // History resets high so a line already held during reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
            alert <= 1'b0;
            prev  <= 1'b1;
        end else begin
            value <= STAT_W'(nxt);
            alert <= alert_next;
            prev  <= din;
        end
    end

endmodule

// File: rtl/stats_engine.sv
// Saturating stat counters raised by a divided random tick and lowered by action-line edges.
module stats_engine
    import stats_pkg::*;
#(
    parameter int unsigned NUM_STATS = STAT_SOCIAL + 1,
    parameter int unsigned STAT_W    = STAT_W_DEF,
    parameter int unsigned SEL_W     = 3,
    parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
    parameter int unsigned INC_STEP  = 1,
    parameter int unsigned DEC_STEP  = 1,
    parameter int unsigned ALERT_LVL = ALERT_LVL_DEF
) (
    input  logic            clk,
    input  logic            reset,
    stats_engine_if.slave   bus
);
    localparam int unsigned     CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]      cnt;
    logic                  tick_int;
    logic [NUM_STATS-1:0]  inc;
    logic [NUM_STATS-1:0]  alert_v;
    logic [NUM_STATS-1:0]  alert_nxt;
    logic                  tick_q;
    logic                  any_q;

    always_comb begin
        tick_int = bus.tick_en && (cnt == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            tick_q <= 1'b0;
            any_q  <= 1'b0;
        end else begin
            if (bus.tick_en)
                cnt <= tick_int ? '0 : cnt + 1'b1;
            tick_q <= tick_int;
            any_q  <= |alert_nxt;
        end
    end

    // Selector values past the last channel match nothing, so that tick is dropped.
    for (genvar i = 0; i < NUM_STATS; i++) begin : g_ch
        logic [STAT_W-1:0] val;

        assign inc[i] = tick_int && (bus.random == SEL_W'(i));

        stat_channel #(
            .STAT_W    (STAT_W),
            .INC_STEP  (INC_STEP),
            .DEC_STEP  (DEC_STEP),
            .ALERT_LVL (ALERT_LVL)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .inc        (inc[i]),
            .din        (bus.inputs[i]),
            .value      (val),
            .alert      (alert_v[i]),
            .alert_next (alert_nxt[i])
        );

        assign bus.stats[i*STAT_W +: STAT_W] = val;
    end

    assign bus.alert     = alert_v;
    assign bus.any_alert = any_q;
    assign bus.tick      = tick_q;

endmodule

// File: tb/tb_stats_engine.sv
// Bench for stats_engine with TICK_DIV=4: directed scenarios plus random traffic against a cycle model.
module tb_stats_engine;
    localparam int NS  = 6;
    localparam int SW  = 4;
    localparam int DIV = 4;
    localparam int MAX = 15;
    localparam int LVL = 12;

    logic clk = 1'b0;
    logic reset;

    stats_engine_if #(.NUM_STATS(NS), .STAT_W(SW), .SEL_W(3)) bus ();

    stats_engine #(.TICK_DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: stat values, last seen action lines, enabled cycles since reset.
    int        m_stat [NS];
    bit [NS-1:0] m_prev;
    int        m_en;
    bit        m_tick;

    function automatic logic [NS*SW-1:0] exp_stats();
        logic [NS*SW-1:0] v;
        for (int i = 0; i < NS; i++) v[i*SW +: SW] = SW'(m_stat[i]);
        return v;
    endfunction

    function automatic logic [NS-1:0] exp_alert();
        logic [NS-1:0] a;
        for (int i = 0; i < NS; i++) a[i] = (m_stat[i] >= LVL);
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock: update the model from the applied stimulus, then compare everything.
    task automatic cycle();
        bit tick_now;
        tick_now = bus.tick_en && ((m_en % DIV) == DIV - 1);
        if (reset) begin
            foreach (m_stat[i]) m_stat[i] = 0;
            m_prev = '1;
            m_en   = 0;
            m_tick = 0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                int s;
                s = m_stat[i];
                if (tick_now && int'(bus.random) == i) s = s + 1;
                if (bus.inputs[i] && !m_prev[i]) s = s - 1;
                if (s < 0) s = 0;
                if (s > MAX) s = MAX;
                m_stat[i] = s;
            end
            m_prev = bus.inputs;
            if (bus.tick_en) m_en++;
            m_tick = tick_now;
        end
        @(posedge clk);
        #1;
        chk("stats",     bus.stats,     exp_stats());
        chk("alert",     bus.alert,     exp_alert());
        chk("any_alert", bus.any_alert, |exp_alert());
        chk("tick",      bus.tick,      m_tick);
    endtask

    task automatic edges_to_tick(output int n);
        n = -1;
        for (int k = 1; k <= 3 * DIV; k++) begin
            cycle();
            if (bus.tick === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    int first;
    bit seen;
    logic [NS*SW-1:0] snap;

    initial begin
        m_prev = '1;
        m_en   = 0;
        m_tick = 0;
        foreach (m_stat[i]) m_stat[i] = 0;

        // Reset with all action lines held high
        reset = 1'b1;
        bus.tick_en = 1'b1;
        bus.inputs  = 6'h3F;
        bus.random  = 3'd2;
        repeat (3) cycle();
        chk("rst_stats", bus.stats, '0);
        chk("rst_alert", bus.alert, '0);
        chk("rst_tick",  bus.tick,  1'b0);

        reset = 1'b0;
        edges_to_tick(first);
        chk("first_tick_edge", first, 4);
        repeat (16) cycle();
        chk("stat2_after_5", bus.stats[2*SW +: SW], 5);
        chk("stat0_untouched", bus.stats[0 +: SW], 0);

        // Ramp stat0 to saturation and catch the alert edge
        bus.random = 3'd0;
        seen = 0;
        repeat (80) begin
            cycle();
            if (!seen && bus.alert[0] === 1'b1) begin
                seen = 1;
                chk("stat0_at_alert", bus.stats[0 +: SW], LVL);
                chk("any_at_alert",   bus.any_alert, 1'b1);
            end
        end
        chk("alert0_seen", seen, 1'b1);
        chk("stat0_sat", bus.stats[0 +: SW], MAX);

        // stat3 to 5, then inc and dec on the same cycle
        bus.random = 3'd3;
        repeat (20) cycle();
        chk("stat3_five", bus.stats[3*SW +: SW], 5);
        bus.random = 3'd7;
        bus.inputs[3] = 1'b0;
        cycle();
        for (int k = 0; k < DIV && (m_en % DIV) != DIV - 1; k++) cycle();
        bus.inputs[3] = 1'b1;
        bus.random = 3'd3;
        cycle();
        chk("inc_dec_cancel_tick", bus.tick, 1'b1);
        chk("inc_dec_cancel", bus.stats[3*SW +: SW], 5);
        bus.random = 3'd7;
        repeat (10) cycle();
        chk("held_once", bus.stats[3*SW +: SW], 5);
        repeat (2) begin
            bus.inputs[3] = 1'b0; cycle();
            bus.inputs[3] = 1'b1; cycle();
        end
        chk("stat3_two_edges", bus.stats[3*SW +: SW], 3);

        // Underflow absorbed at zero, then alert falls from 12 to 11
        repeat (3) begin
            bus.inputs[1] = 1'b0; cycle();
            bus.inputs[1] = 1'b1; cycle();
        end
        chk("stat1_no_wrap", bus.stats[1*SW +: SW], 0);
        bus.random = 3'd1;
        for (int k = 0; k < 100 && m_stat[1] < LVL; k++) cycle();
        bus.random = 3'd7;
        cycle();
        chk("stat1_twelve", bus.stats[1*SW +: SW], LVL);
        chk("alert1_high",  bus.alert[1], 1'b1);
        bus.inputs[1] = 1'b0; cycle();
        bus.inputs[1] = 1'b1; cycle();
        chk("stat1_eleven", bus.stats[1*SW +: SW], LVL - 1);
        chk("alert1_low",   bus.alert[1], 1'b0);

        // Out-of-range selectors drop the tick
        snap = exp_stats();
        for (int k = 0; k < 32; k++) begin
            bus.random = (k % 2 == 0) ? 3'd6 : 3'd7;
            cycle();
        end
        chk("oor_unchanged", bus.stats, snap);

        // Pause at cnt=2
        for (int k = 0; k < DIV && (m_en % DIV) != 2; k++) cycle();
        bus.tick_en = 1'b0;
        seen = 0;
        repeat (10) begin
            cycle();
            if (bus.tick === 1'b1) seen = 1;
        end
        chk("paused_no_tick", seen, 1'b0);
        bus.tick_en = 1'b1;
        edges_to_tick(first);
        chk("resume_tick_edge", first, 2);

        // Reset right on the would-be tick cycle
        for (int k = 0; k < DIV && (m_en % DIV) != DIV - 1; k++) cycle();
        reset = 1'b1;
        cycle();
        chk("rst_kills_tick", bus.tick, 1'b0);
        reset = 1'b0;
        edges_to_tick(first);
        chk("post_rst_tick_edge", first, 4);

        // Random traffic against the model
        repeat (400) begin
            bus.inputs  = NS'($urandom & $urandom & $urandom);
            bus.random  = 3'($urandom_range(0, 7));
            bus.tick_en = ($urandom_range(0, 9) != 0);
            reset       = ($urandom_range(0, 149) == 0);
            cycle();
        end
        reset = 1'b0;
        bus.inputs = '1;
        bus.tick_en = 1'b1;
        repeat (200) begin
            bus.random = 3'($urandom_range(0, 5));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
